// File: rtl/prt_dp_lb_tmo_bridge_pkg.sv
// Shared DP definitions for the local-bus timeout bridge: FSM state encoding
// and the default data word returned when a downstream read times out.
package prt_dp_lb_tmo_bridge_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lb_tmo_state_e;

  localparam logic [31:0] DP_TMO_DAT_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/prt_dp_lb_tmo_bridge.sv
// Local-bus bridge: registers upstream strobes onto the downstream bus, posts
// writes, and guards reads with a timeout that returns a filler word.
module prt_dp_lb_tmo_bridge
  import prt_dp_lb_tmo_bridge_pkg::*;
#(
  parameter int          P_ADR_WIDTH  = 16,
  parameter int          P_TMO_CYCLES = 1024,
  parameter logic [31:0] P_TMO_DAT    = DP_TMO_DAT_DEF
) (
  input  logic                   CLK_IN,
  input  logic                   RST_IN,
  input  logic [P_ADR_WIDTH-1:0] LB_UP_ADR_IN,
  input  logic [31:0]            LB_UP_DIN_IN,
  input  logic                   LB_UP_WR_IN,
  input  logic                   LB_UP_RD_IN,
  output logic [31:0]            LB_UP_DOUT_OUT,
  output logic                   LB_UP_VLD_OUT,
  output logic [P_ADR_WIDTH-1:0] LB_DWN_ADR_OUT,
  output logic [31:0]            LB_DWN_DIN_OUT,
  output logic                   LB_DWN_WR_OUT,
  output logic                   LB_DWN_RD_OUT,
  input  logic [31:0]            LB_DWN_DOUT_IN,
  input  logic                   LB_DWN_VLD_IN,
  input  logic                   STA_CLR_IN,
  output logic                   STA_TMO_OUT,
  output logic                   STA_OVR_OUT,
  output logic [7:0]             STA_TMO_CNT_OUT
);

  localparam int CNT_W = $clog2(P_TMO_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(P_TMO_CYCLES);

  lb_tmo_state_e    state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             rsp_ok;
  logic             tmo_evt;
  logic             ovr_evt;

  // tmo_cnt equals k during cycle t+k; a response in cycle t itself belongs
  // to an earlier, abandoned read and is ignored.
  always_comb begin
    rsp_ok  = 1'b0;
    tmo_evt = 1'b0;
    ovr_evt = 1'b0;
    if (state == ST_WAIT) begin
      rsp_ok  = LB_DWN_VLD_IN && (tmo_cnt != '0);
      tmo_evt = !rsp_ok && (tmo_cnt == TMO_LAST);
      ovr_evt = LB_UP_WR_IN || LB_UP_RD_IN;
    end else begin
      ovr_evt = LB_UP_WR_IN && LB_UP_RD_IN;
    end
  end

  // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state           <= ST_IDLE;
      tmo_cnt         <= '0;
      LB_UP_DOUT_OUT  <= '0;
      LB_UP_VLD_OUT   <= 1'b0;
      LB_DWN_ADR_OUT  <= '0;
      LB_DWN_DIN_OUT  <= '0;
      LB_DWN_WR_OUT   <= 1'b0;
      LB_DWN_RD_OUT   <= 1'b0;
      STA_TMO_OUT     <= 1'b0;
      STA_OVR_OUT     <= 1'b0;
      STA_TMO_CNT_OUT <= '0;
    end else begin
      LB_UP_VLD_OUT <= 1'b0;
      LB_DWN_WR_OUT <= 1'b0;
      LB_DWN_RD_OUT <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (LB_UP_WR_IN || LB_UP_RD_IN) begin
            LB_DWN_ADR_OUT <= LB_UP_ADR_IN;
            LB_DWN_DIN_OUT <= LB_UP_DIN_IN;
            if (LB_UP_RD_IN) begin
              LB_DWN_RD_OUT <= 1'b1;
              tmo_cnt       <= '0;
              state         <= ST_WAIT;
            end else begin
              LB_DWN_WR_OUT <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (rsp_ok) begin
            LB_UP_VLD_OUT  <= 1'b1;
            LB_UP_DOUT_OUT <= LB_DWN_DOUT_IN;
            state          <= ST_IDLE;
          end else if (tmo_evt) begin
            LB_UP_VLD_OUT  <= 1'b1;
            LB_UP_DOUT_OUT <= P_TMO_DAT;
            state          <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A set event in the same cycle as a clear keeps the flag/count.
      if (tmo_evt) begin
        STA_TMO_OUT <= 1'b1;
        if (STA_TMO_CNT_OUT != 8'hFF) STA_TMO_CNT_OUT <= STA_TMO_CNT_OUT + 8'd1;
      end else if (STA_CLR_IN) begin
        STA_TMO_OUT     <= 1'b0;
        STA_TMO_CNT_OUT <= '0;
      end

      if (ovr_evt)         STA_OVR_OUT <= 1'b1;
      else if (STA_CLR_IN) STA_OVR_OUT <= 1'b0;
    end
  end

endmodule
